// File: rtl/ptp_pkg.sv
// ptp_pkg: constants and types shared by the ptp_a deserializer and the
// ptp_b serializer. A frame is 20 bytes, packed MSB-first into five 32-bit words.
package ptp_pkg;

  localparam int PTP_WORD_W          = 32;
  localparam int PTP_NUM_WORDS       = 5;
  localparam int PTP_FRAME_W         = 160;
  localparam int PTP_BYTES_PER_FRAME = 20;
  localparam int PTP_BYTE_W          = 8;

  typedef logic [4:0] ptp_count_t;

  // Index of the byte whose capture completes a frame.
  localparam ptp_count_t PTP_LAST_BYTE = ptp_count_t'(PTP_BYTES_PER_FRAME - 1);

endpackage

// File: rtl/ptp_strobe_edge.sv
// ptp_strobe_edge: turns the byte strobe into a one-cycle pulse in clk_i.
// When PTP_A_SYNC_EN is defined, ctrl_i first passes through a 2-flop
// synchroniser; otherwise it feeds the edge detector directly.
// Ports:
//   clk_i    - system clock
//   reset_ni - asynchronous active-low reset
//   ctrl_i   - raw byte strobe
//   edge_o   - high for one cycle per rising edge of the (synchronised) strobe
module ptp_strobe_edge (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic ctrl_i,
  output logic edge_o
);

  logic ctrl_s;
  logic ctrl_q;

`ifdef PTP_A_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], ctrl_i};
    end
  end

  assign ctrl_s = sync_q[1];
`else
  assign ctrl_s = ctrl_i;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ctrl_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_s;
    end
  end

  // Combinational so the byte is captured on the same edge that first
  // sees the strobe high; a held strobe yields only one pulse.
  assign edge_o = ctrl_s & ~ctrl_q;

endmodule

// File: rtl/ptp_a.sv
// ptp_a: byte-wide deserializer. Collects 20 strobed bytes MSB-first into a
// shadow frame and publishes all five 32-bit words atomically on completion.
// Optional macro PTP_A_SYNC_EN adds a 2-flop synchroniser on control_i.
// Ports:
//   clk_i, reset_ni            - clock, asynchronous active-low reset
//   control_i                  - byte strobe (rising edge accepts value_i)
//   restart_i                  - synchronous restart, drops the partial frame
//   value_i[7:0]               - incoming byte
//   value_a_o..value_e_o[31:0] - published words (value_a_o = bytes 0..3)
//   valid_o                    - one-cycle pulse on publish
//   count_o[4:0]               - bytes accepted in the current frame
module ptp_a
  import ptp_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  control_i,
  input  logic                  restart_i,
  input  logic [PTP_BYTE_W-1:0] value_i,
  output logic [PTP_WORD_W-1:0] value_a_o,
  output logic [PTP_WORD_W-1:0] value_b_o,
  output logic [PTP_WORD_W-1:0] value_c_o,
  output logic [PTP_WORD_W-1:0] value_d_o,
  output logic [PTP_WORD_W-1:0] value_e_o,
  output logic                  valid_o,
  output logic [4:0]            count_o
);

  logic                   edge_s;
  logic [PTP_FRAME_W-1:0] shadow_q, shadow_d;
  logic [PTP_FRAME_W-1:0] pub_q, pub_d;
  ptp_count_t             count_q, count_d;
  logic                   valid_q, valid_d;

  ptp_strobe_edge u_strobe_edge (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .ctrl_i   (control_i),
    .edge_o   (edge_s)
  );

  always_comb begin
    shadow_d = shadow_q;
    pub_d    = pub_q;
    count_d  = count_q;
    valid_d  = 1'b0;
    // Restart has priority: a byte arriving in the same cycle is dropped.
    if (restart_i) begin
      count_d = '0;
    end else if (edge_s) begin
      for (int i = 0; i < PTP_BYTES_PER_FRAME; i++) begin
        if (count_q == ptp_count_t'(i)) begin
          shadow_d[PTP_FRAME_W-1-PTP_BYTE_W*i -: PTP_BYTE_W] = value_i;
        end
      end
      // Publish uses shadow_d so the final byte lands in the same cycle.
      if (count_q == PTP_LAST_BYTE) begin
        pub_d   = shadow_d;
        valid_d = 1'b1;
        count_d = '0;
      end else begin
        count_d = ptp_count_t'(count_q + 5'd1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      shadow_q <= '0;
      pub_q    <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      pub_q    <= pub_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  assign value_a_o = pub_q[159:128];
  assign value_b_o = pub_q[127:96];
  assign value_c_o = pub_q[95:64];
  assign value_d_o = pub_q[63:32];
  assign value_e_o = pub_q[31:0];
  assign valid_o   = valid_q;
  assign count_o   = count_q;

endmodule

// File: tb/tb_ptp_a.sv
module tb_ptp_a;

`ifdef PTP_A_SYNC_EN
  localparam int LAT  = 2;
  localparam int HOLD = 2;
`else
  localparam int LAT  = 0;
  localparam int HOLD = 1;
`endif

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        control_i;
  logic        restart_i;
  logic [7:0]  value_i;
  logic [31:0] value_a_o, value_b_o, value_c_o, value_d_o, value_e_o;
  logic        valid_o;
  logic [4:0]  count_o;
  logic [159:0] dut_pub;

  int checks = 0;
  int fails  = 0;

  // Reference model: list of bytes in the open frame, last published frame,
  // and the queue of frames the DUT still owes.
  logic [7:0]   m_bytes[$];
  logic [159:0] m_pub;
  logic [159:0] exp_q[$];

  ptp_a dut (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .control_i (control_i),
    .restart_i (restart_i),
    .value_i   (value_i),
    .value_a_o (value_a_o),
    .value_b_o (value_b_o),
    .value_c_o (value_c_o),
    .value_d_o (value_d_o),
    .value_e_o (value_e_o),
    .valid_o   (valid_o),
    .count_o   (count_o)
  );

  always #5 clk_i = ~clk_i;

  assign dut_pub = {value_a_o, value_b_o, value_c_o, value_d_o, value_e_o};

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: every valid pulse must match the oldest owed frame.
  always @(posedge clk_i) begin
    #1;
    if (reset_ni === 1'b1 && valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL frame_unexpected actual=%h required=none", dut_pub);
      end else begin
        chk("frame", dut_pub, exp_q.pop_front());
      end
    end
  end

  function automatic logic [159:0] pack_frame();
    logic [159:0] f;
    f = '0;
    foreach (m_bytes[i]) f = {f[151:0], m_bytes[i]};
    return f;
  endfunction

  // Present one byte with strobe high for 'hi' cycles; rs asserts restart_i
  // in the very cycle the DUT would capture it. Called at a negedge.
  task automatic send(input logic [7:0] b, input int hi, input bit rs);
    int n;
    int old_cnt;
    int exp_cnt;
    bit exp_vld;
    n = hi + HOLD;
    if (n < LAT + 2) n = LAT + 2;
    old_cnt = m_bytes.size();
    exp_cnt = old_cnt;
    exp_vld = 1'b0;
    for (int k = 0; k < n; k++) begin
      value_i   = b;
      control_i = (k < hi);
      restart_i = rs && (k == LAT);
      if (k == LAT) begin
        chk("count_pre", 160'(count_o), 160'(old_cnt));
        if (rs) begin
          m_bytes.delete();
        end else begin
          m_bytes.push_back(b);
          if (m_bytes.size() == 20) begin
            m_pub = pack_frame();
            exp_q.push_back(m_pub);
            m_bytes.delete();
            exp_vld = 1'b1;
          end
        end
        exp_cnt = m_bytes.size();
      end
      if (k == LAT + 1) begin
        chk("count_post", 160'(count_o), 160'(exp_cnt));
        chk("valid_post", 160'(valid_o), 160'(exp_vld));
        chk("outputs", dut_pub, m_pub);
      end
      @(negedge clk_i);
    end
    control_i = 1'b0;
    restart_i = 1'b0;
  endtask

  task automatic do_restart();
    restart_i = 1'b1;
    @(negedge clk_i);
    restart_i = 1'b0;
    m_bytes.delete();
    chk("count_restart", 160'(count_o), 160'(0));
  endtask

  task automatic do_reset();
    reset_ni = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    m_bytes.delete();
    m_pub = '0;
    chk("reset_outputs", dut_pub, 160'(0));
    chk("reset_count", 160'(count_o), 160'(0));
    chk("reset_valid", 160'(valid_o), 160'(0));
    reset_ni = 1'b1;
    @(negedge clk_i);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_ni  = 1'b0;
    control_i = 1'b0;
    restart_i = 1'b0;
    value_i   = 8'h00;
    m_pub     = '0;
    @(negedge clk_i);
    do_reset();

    // Full frame 0x00..0x13
    for (int i = 0; i < 20; i++) send(8'(i), HOLD, 1'b0);
    chk("word_a", 160'(value_a_o), 160'(32'h00010203));
    chk("word_e", 160'(value_e_o), 160'(32'h10111213));

    // Atomicity: partial frame of 0xFF stays invisible
    for (int i = 0; i < 10; i++) send(8'hFF, HOLD, 1'b0);
    chk("atomic_count", 160'(count_o), 160'(10));
    chk("atomic_a", 160'(value_a_o), 160'(32'h00010203));

    // Restart collision
    do_restart();
    for (int i = 0; i < 5; i++) send(8'($urandom_range(0, 255)), HOLD, 1'b0);
    send(8'hAA, HOLD, 1'b1);
    chk("collide_count", 160'(count_o), 160'(0));
    for (int i = 0; i < 20; i++) send(8'(8'h40 + i), HOLD, 1'b0);

    // Held strobe: one byte only
    send(8'h5C, 10, 1'b0);
    chk("held_count", 160'(count_o), 160'(1));

    // Reset mid-frame after 7 bytes, then a fresh frame
    for (int i = 0; i < 6; i++) send(8'($urandom_range(0, 255)), HOLD, 1'b0);
    do_reset();
    for (int i = 0; i < 20; i++) send(8'($urandom_range(0, 255)), HOLD, 1'b0);

    // Random traffic with occasional restart collisions and long strobes
    for (int i = 0; i < 120; i++) begin
      send(8'($urandom_range(0, 255)), HOLD + int'($urandom_range(0, 2)),
           ($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 4; i++) @(negedge clk_i);

    chk("owed_frames", 160'(exp_q.size()), 160'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
